// File: rtl/rsa_word_stream.sv
// Word-serial front/back end for the 4096-bit RSA engine.
// Assembles message/exponent/modulus from a 64-bit input stream, starts the
// engine with a one-cycle go pulse, captures the cypher on done and streams
// it back out as 64-bit words, least-significant word first.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_LOAD  | accepting operand words (192 total, message/exponent/modulus)
// S_GO    | one-cycle start pulse to the engine
// S_ARM   | one cycle with done ignored (engine still shows previous done)
// S_WAIT  | waiting for the engine's done level, no timeout
// S_DRAIN | streaming the captured result out, one word per handshake
module rsa_word_stream #(
    parameter int DATA_WIDTH = 64,
    parameter int RSA_WIDTH  = 4096,
    parameter int WORDS      = RSA_WIDTH / DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [RSA_WIDTH-1:0]  message,
    output logic [RSA_WIDTH-1:0]  exponent,
    output logic [RSA_WIDTH-1:0]  modulus,
    output logic                  go,
    input  logic                  done,
    input  logic [RSA_WIDTH-1:0]  cypher,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam int         LSB_W    = $clog2(DATA_WIDTH);
    localparam logic [7:0] LAST_IN  = 8'(3 * WORDS - 1);
    localparam logic [5:0] LAST_OUT = 6'(WORDS - 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_GO,
        S_ARM,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [7:0]           cnt;
    logic [RSA_WIDTH-1:0] result;
    logic [LSB_W+5:0]     slot_base;
    logic                 in_fire;
    logic                 out_fire;

    // cnt[5:0] is the word slot within the current operand or the result
    assign slot_base = {cnt[5:0], {LSB_W{1'b0}}};
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_data  = result[slot_base +: DATA_WIDTH];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/control outputs; handshakes use the raw
    // inputs here so the comb block never depends on its own outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        go        = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b1;
        case (state)
            S_LOAD: begin
                in_ready = !reset;
                busy     = 1'b0;
                if (in_valid && !reset && cnt == LAST_IN) begin
                    state_nxt = S_GO;
                end
            end
            S_GO: begin
                go        = 1'b1;
                state_nxt = S_ARM;
            end
            S_ARM: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (done) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_last  = (cnt[5:0] == LAST_OUT);
                if (out_ready && cnt[5:0] == LAST_OUT) begin
                    state_nxt = S_LOAD;
                end
            end
            default: begin
                state_nxt = S_LOAD;
            end
        endcase
    end

    // Word counter, operand assembly and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= 8'd0;
            message  <= '0;
            exponent <= '0;
            modulus  <= '0;
            result   <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_fire) begin
                        case (cnt[7:6])
                            2'd0:    message[slot_base +: DATA_WIDTH]  <= in_data;
                            2'd1:    exponent[slot_base +: DATA_WIDTH] <= in_data;
                            2'd2:    modulus[slot_base +: DATA_WIDTH]  <= in_data;
                            default: ;
                        endcase
                        cnt <= (cnt == LAST_IN) ? 8'd0 : cnt + 8'd1;
                    end
                end
                S_WAIT: begin
                    if (done) begin
                        result <= cypher;
                        cnt    <= 8'd0;
                    end
                end
                S_DRAIN: begin
                    if (out_fire) begin
                        cnt <= (cnt[5:0] == LAST_OUT) ? 8'd0 : cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_word_stream.sv
// Bench for rsa_word_stream: directed runs against a phase-level model and
// a simple engine model that raises done a fixed latency after go.
`timescale 1ns/1ps
module tb_rsa_word_stream;

    localparam int DW = 64;
    localparam int RW = 4096;
    localparam int LATENCY = 50;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [RW-1:0] message;
    logic [RW-1:0] exponent;
    logic [RW-1:0] modulus;
    logic          go;
    logic          done;
    logic [RW-1:0] cypher;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    rsa_word_stream dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .message   (message),
        .exponent  (exponent),
        .modulus   (modulus),
        .go        (go),
        .done      (done),
        .cypher    (cypher),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Operand stream: word k of the 192-word sequence
    function automatic logic [63:0] word_of(input int k);
        case (k / 64)
            0:       return 64'(k % 64);
            1:       return 64'h100 + 64'(k % 64);
            default: return 64'h200 + 64'(k % 64);
        endcase
    endfunction

    function automatic logic [RW-1:0] make_cypher(input logic [63:0] base);
        logic [RW-1:0] v;
        for (int i = 0; i < 64; i++) v[i*64 +: 64] = base + 64'(i);
        return v;
    endfunction

    // Engine model: done drops the cycle after go, rises LATENCY cycles later
    logic [63:0] cyph_base = 64'hC000;
    initial begin
        forever begin
            @(negedge clk);
            if (go === 1'b1) begin
                @(posedge clk); #1;
                done = 1'b0;
                repeat (LATENCY) @(posedge clk);
                #1;
                cypher = make_cypher(cyph_base);
                done   = 1'b1;
            end
        end
    end

    // Phase-level reference model and per-cycle compare
    bit            m_init = 0;
    bit            m_loading, m_go, m_arm, m_wait, m_drain;
    int            m_acc, m_idx;
    logic [RW-1:0] m_res;
    int            go_cnt = 0;
    int            last_cnt = 0;
    int            rec_n = 0;
    logic [63:0]   rec [64];

    always @(negedge clk) begin
        if (m_init) begin
            chk("in_ready", {63'b0, in_ready}, {63'b0, m_loading && !reset});
            chk("go", {63'b0, go}, {63'b0, m_go});
            chk("busy", {63'b0, busy}, {63'b0, !m_loading});
            chk("out_valid", {63'b0, out_valid}, {63'b0, m_drain});
            if (m_drain) begin
                chk("out_data", out_data, m_res[m_idx*64 +: 64]);
                chk("out_last", {63'b0, out_last}, {63'b0, m_idx == 63});
            end
            if (go === 1'b1) go_cnt++;
            if (out_valid === 1'b1 && out_ready && !reset) begin
                if (rec_n < 64) rec[rec_n] = out_data;
                rec_n++;
                if (out_last === 1'b1) last_cnt++;
            end
        end
        if (reset) begin
            m_init = 1; m_loading = 1; m_acc = 0;
            m_go = 0; m_arm = 0; m_wait = 0; m_drain = 0; m_idx = 0;
        end else if (m_init) begin
            if (m_loading) begin
                if (in_valid) begin
                    m_acc++;
                    if (m_acc == 192) begin
                        m_loading = 0; m_go = 1; m_acc = 0;
                    end
                end
            end else if (m_go) begin
                m_go = 0; m_arm = 1;
            end else if (m_arm) begin
                m_arm = 0; m_wait = 1;
            end else if (m_wait) begin
                if (done) begin
                    m_res = cypher; m_wait = 0; m_drain = 1; m_idx = 0;
                end
            end else if (m_drain) begin
                if (out_ready) begin
                    m_idx++;
                    if (m_idx == 64) begin
                        m_drain = 0; m_loading = 1;
                    end
                end
            end
        end
    end

    task automatic send(input int from, input int to, input bit bubbles);
        int k = from;
        int guard = 0;
        bit acc;
        while (k < to && guard < 5000) begin
            if (bubbles && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = word_of(k);
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            guard++;
            if (acc) k++;
        end
        in_valid = 1'b0;
        if (k < to) chk("send_timeout", 64'(k), 64'(to));
    endtask

    task automatic drain(input int stall_at, input int stall_len, input logic [63:0] stall_val);
        int  got = 0;
        int  guard = 0;
        bit  stalled = 0;
        out_ready = 1'b1;
        while (got < 64 && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (out_valid && out_ready) got++;
            @(posedge clk); #1;
            if (got == stall_at && stall_len > 0 && !stalled) begin
                stalled   = 1;
                out_ready = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    chk("stall_valid", {63'b0, out_valid}, 64'd1);
                    chk("stall_data", out_data, stall_val);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        end
        if (got < 64) chk("drain_timeout", 64'(got), 64'd64);
    endtask

    task automatic check_buses(input string tag);
        for (int k = 0; k < 192; k++) begin
            logic [63:0] v;
            case (k / 64)
                0:       v = message[(k % 64)*64 +: 64];
                1:       v = exponent[(k % 64)*64 +: 64];
                default: v = modulus[(k % 64)*64 +: 64];
            endcase
            chk(tag, v, word_of(k));
        end
    endtask

    task automatic check_result(input string tag, input logic [63:0] base, input int go_exp);
        chk({tag, "_count"}, 64'(rec_n), 64'd64);
        for (int i = 0; i < 64; i++) chk(tag, rec[i], base + 64'(i));
        chk({tag, "_last_cnt"}, 64'(last_cnt), 64'd1);
        chk({tag, "_go_cnt"}, 64'(go_cnt), 64'(go_exp));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; done = 1'b0; cypher = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
        chk("rst_go", {63'b0, go}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_out_last", {63'b0, out_last}, 64'd0);
        chk("rst_message", {63'b0, |message}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Run 1: no bubbles, 10-cycle stall on word 5
        cyph_base = 64'hC000;
        send(0, 192, 1'b0);
        chk("msg_word1", message[127:64], 64'd1);
        chk("mod_top", modulus[4095:4032], 64'h23F);
        check_buses("run1_operand");
        rec_n = 0; last_cnt = 0;
        drain(5, 10, 64'hC005);
        check_result("run1_out", 64'hC000, 1);

        // Run 2: back-to-back, random input bubbles, stale done from run 1
        cyph_base = 64'hD000;
        send(0, 192, 1'b1);
        check_buses("run2_operand");
        rec_n = 0; last_cnt = 0;
        drain(-1, 0, 64'h0);
        check_result("run2_out", 64'hD000, 2);

        // Run 3: reset after 100 words, then a full fresh load
        send(0, 100, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", {63'b0, in_ready}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_message", {63'b0, |message}, 64'd0);
        chk("midrst_exponent", {63'b0, |exponent}, 64'd0);
        chk("midrst_modulus", {63'b0, |modulus}, 64'd0);
        chk("midrst_out_data", out_data, 64'd0);
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        chk("midrst_go", {63'b0, go}, 64'd0);
        chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        cyph_base = 64'hE000;
        send(0, 191, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("no_go_at_191", 64'(go_cnt), 64'd2);
        send(191, 192, 1'b0);
        check_buses("run3_operand");
        rec_n = 0; last_cnt = 0;
        drain(-1, 0, 64'h0);
        check_result("run3_out", 64'hE000, 3);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
